psram_qspi_responder: RTL

- Synthesizable QSPI PSRAM device model, the memory-side end of the PSRAM QSPI link driven by the board's PSRAM controller.
- Observes sclk, cs_n and sio[3:0] from the initiator and decodes SPI/QPI commands.
- Serves writes and reads from an internal byte array.
- Used for loopback bring-up on the board and as the bench target for the controller.

---
 rtl/psram_qspi_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/psram_qspi_responder.sv
// QSPI PSRAM device model: samples sclk/cs_n/sio from the initiator through
// synchronisers, decodes SPI/QPI commands and serves reads/writes from a byte array.
module psram_qspi_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYC    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic       sio_oe,
  output logic       qpi_mode,
  output logic       busy
);

  localparam int CNT_W = $clog2(WAIT_CYC + 9);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RDATA,
    S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [3:0]             r_sio_sync [SYNC_STAGES];
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic [7:0]        r_mem [2**ADDR_W];
  logic [7:0]        r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_qpi;
  logic              r_rst_en;
  logic              r_wr;
  logic              r_oe;
  logic [3:0]        r_out;

  logic       w_sclk;
  logic       w_cs;
  logic [3:0] w_sio;
  logic       w_rise;
  logic       w_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic [7:0] w_byte;
  logic       w_cmd_last;
  logic       w_cmd_rw;
  logic [7:0] w_rd_byte;
  logic       w_mem_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sio_sync[i] <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync[0] <= sclk;
      r_cs_sync[0]   <= cs_n;
      r_sio_sync[0]  <= sio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_sio_sync[i]  <= r_sio_sync[i-1];
      end
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
    end
  end

  // cs_n history resets to "low" so a select held across rst never looks like a new fall
  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_sio     = r_sio_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_cs_fall = ~w_cs & r_cs_d;
  assign w_cs_rise = w_cs & ~r_cs_d;

  assign w_byte     = r_qpi ? {r_shift[3:0], w_sio} : {r_shift[6:0], w_sio[0]};
  assign w_cmd_last = r_qpi ? (r_cnt == CNT_W'(1)) : (r_cnt == CNT_W'(7));
  assign w_cmd_rw   = r_qpi && ((w_byte == 8'h38) || (w_byte == 8'hEB));
  assign w_rd_byte  = r_mem[r_addr];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_nx = S_CMD;
      S_CMD:   if (w_rise && w_cmd_last) w_state_nx = w_cmd_rw ? S_ADDR : S_IGNORE;
      S_ADDR:  if (w_rise && (r_cnt == CNT_W'(5))) w_state_nx = r_wr ? S_WDATA : S_WAIT;
      S_WAIT:  if (w_fall && (r_cnt == WAIT_LAST)) w_state_nx = S_RDATA;
      default: ;
    endcase
    if (w_cs_rise) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_qpi    <= 1'b0;
      r_rst_en <= 1'b0;
      r_wr     <= 1'b0;
      r_oe     <= 1'b0;
      r_out    <= '0;
    end else if (w_cs_rise) begin
      r_oe  <= 1'b0;
      r_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) begin
          r_cnt   <= '0;
          r_shift <= '0;
        end
        S_CMD: if (w_rise) begin
          r_shift <= w_byte;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_cmd_last) begin
            r_cnt    <= '0;
            r_rst_en <= (w_byte == 8'h66);
            r_wr     <= (w_byte == 8'h38);
            case (w_byte)
              8'h35:   r_qpi <= 1'b1;
              8'hF5:   if (r_qpi) r_qpi <= 1'b0;
              8'h99:   if (r_rst_en) r_qpi <= 1'b0;
              default: ;
            endcase
          end
        end
        S_ADDR: if (w_rise) begin
          r_addr <= ADDR_W'({r_addr, w_sio});
          r_cnt  <= (r_cnt == CNT_W'(5)) ? '0 : r_cnt + CNT_W'(1);
        end
        S_WDATA: if (w_rise) begin
          if (r_cnt[0]) r_addr <= r_addr + ADDR_W'(1);
          else          r_shift <= {4'h0, w_sio};
          r_cnt[0] <= ~r_cnt[0];
        end
        S_WAIT: begin
          if (w_rise && (r_cnt != WAIT_LAST)) r_cnt <= r_cnt + CNT_W'(1);
          if (w_fall && (r_cnt == WAIT_LAST)) begin
            r_oe  <= 1'b1;
            r_out <= w_rd_byte[7:4];
            r_cnt <= CNT_W'(1);
          end
        end
        // r_cnt[0] set means the low nibble of the current byte goes out next
        S_RDATA: if (w_fall) begin
          if (r_cnt[0]) begin
            r_out  <= w_rd_byte[3:0];
            r_addr <= r_addr + ADDR_W'(1);
          end else begin
            r_out <= w_rd_byte[7:4];
          end
          r_cnt[0] <= ~r_cnt[0];
        end
        default: ;
      endcase
    end
  end

  assign w_mem_we = !rst && !w_cs_rise && (r_state == S_WDATA) && w_rise && r_cnt[0];

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= {r_shift[3:0], w_sio};
  end

  assign sio_out  = r_out;
  assign sio_oe   = r_oe;
  assign qpi_mode = r_qpi;
  assign busy     = (r_state != S_IDLE);

endmodule
